updown_counter_lim: RTL and testbench
=====================================

Name: updown_counter_lim

Overview:
- Parametrised successor to the 4-bit up/down loadable counter: configurable width and step size, programmable lower/upper limits, and runtime wrap-or-saturate mode.
- Produces a boundary-event pulse, sticky overflow/underflow flags and a config-error indication.
- Used as the general-purpose counting primitive for timers, address generators and rate dividers in the core.

Parameters:
WIDTH, 8, counter/limit/data width in bits (>=2)
STEP_W, 4, width of step input
RESET_VAL, 0, count value after reset (must fit in WIDTH)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
enable  input  1  count-enable for this cycle
up_down  input  1  1 = count up, 0 = count down
load  input  1  synchronous load of data_in
data_in  input  WIDTH  load value
step  input  STEP_W  increment/decrement amount per enabled cycle
lim_lo  input  WIDTH  lower limit (inclusive)
lim_hi  input  WIDTH  upper limit (inclusive)
sat_mode  input  1  1 = saturate at limit, 0 = wrap to opposite limit
clr_flags  input  1  synchronous clear of ovf/unf sticky flags
count  output  WIDTH  registered counter value
evt  output  1  registered one-cycle pulse: limit crossed (wrap or clamp) this edge
ovf  output  1  sticky: up-overflow has occurred
unf  output  1  sticky: down-underflow has occurred
cfg_err  output  1  combinational: lim_lo > lim_hi

Behaviour:
- Reset (async, immediate, no clock needed): count=RESET_VAL, evt=0, ovf=0, unf=0. cfg_err is combinational and stays valid through reset.
- Priority per edge: rst > load > enable. Otherwise hold, and evt=0.
- Load: count<=data_in one edge later, regardless of enable, limits or cfg_err. Values outside [lim_lo,lim_hi] are accepted. No evt and no flag change.
- Counting applies when enable=1, load=0 and cfg_err=0. When cfg_err=1, count holds and evt=0.
- All arithmetic uses WIDTH+1 bits, with step zero-extended, so no intermediate wraps at 2^WIDTH.
- Up: sum = count + step.
  - If sum > lim_hi: overflow event. Wrap mode sets count<=lim_lo (no remainder carried); saturate mode sets count<=lim_hi.
  - Else count<=sum.
- Down: if count < lim_lo + step: underflow event. Wrap mode sets count<=lim_hi; saturate mode sets count<=lim_lo.
  - Else count<=count-step.
- Event edge: evt=1 for exactly that cycle, and ovf or unf is set.
  - In saturate mode, every enabled cycle sitting at the limit with step>0 re-detects the event, so evt stays high each such cycle.
- step=0: count holds, no event, even at or beyond a limit.
- Out-of-range count (after a load or a limit change) is handled by the same comparisons. Example: up with count > lim_hi gives an overflow event.
- clr_flags clears ovf/unf on the edge. A simultaneous new event sets its flag, so set wins over clear.
- sat_mode, up_down, step and limits are sampled each edge. A mid-count change takes effect on the next enabled edge.
- Latency: one clock from input to count/evt.

Test Plan:
1. WIDTH=8, count running at 0x37, assert rst between edges -> count=0x00, evt/ovf/unf=0 immediately. Release rst; first enabled up edge with step=1 -> count=0x01.
2. lim_lo=2, lim_hi=10, step=3, sat_mode=0, load 4, then enable up -> count 4,7,10,2. evt high only on the edge producing 2; ovf=1 thereafter, unf=0.
3. lim_lo=5, lim_hi=200, step=4, sat_mode=1, load 11, enable down -> count 11,7,5,5. evt high on both edges yielding 5; unf=1.
4. load=1 with enable=1, data_in=0xF0, lim_hi=0x20 -> count=0xF0, evt=0. Next enabled up edge with step=1, wrap mode -> count=lim_lo, evt=1, ovf=1.
5. lim_lo=0, lim_hi=255, step=1, wrap mode: up from 255 -> 0 with ovf=1; down from 0 -> 255 with unf=1. Confirms WIDTH+1 arithmetic.
6. lim_lo=20, lim_hi=10, enable=1 -> cfg_err=1, count holds, evt=0. Then with legal limits, assert clr_flags on the same edge as an overflow -> ovf remains 1. clr_flags alone on the next edge -> ovf=0.

Source files
------------

// File: rtl/updown_counter_lim.sv
// Up/down counter with a programmable step, inclusive lo/hi limits, wrap or saturate, and sticky ovf/unf flags.
// Latency: one clock from the inputs to count/evt/ovf/unf; cfg_err is combinational.
// Backpressure: none; the counter takes its inputs on every edge and has no stall.
module updown_counter_lim #(
  parameter int              WIDTH     = 8,
  parameter int              STEP_W    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              up_down,
  input  logic              load,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  lim_lo,
  input  logic [WIDTH-1:0]  lim_hi,
  input  logic              sat_mode,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  count,
  output logic              evt,
  output logic              ovf,
  output logic              unf,
  output logic              cfg_err
);

  // One extra bit over the wider of count and step, so that neither
  // count+step nor lim_lo+step can wrap before it is compared.
  localparam int AW = ((STEP_W > WIDTH) ? STEP_W : WIDTH) + 1;

  logic [AW-1:0]    cnt_x;
  logic [AW-1:0]    step_x;
  logic [AW-1:0]    lo_x;
  logic [AW-1:0]    hi_x;
  logic [AW-1:0]    sum_x;
  logic [AW-1:0]    diff_x;
  logic [AW-1:0]    floor_x;
  logic [WIDTH-1:0] nxt_count;
  logic             hit_ovf;
  logic             hit_unf;

  assign cfg_err = (lim_lo > lim_hi);

  assign cnt_x   = AW'(count);
  assign step_x  = AW'(step);
  assign lo_x    = AW'(lim_lo);
  assign hi_x    = AW'(lim_hi);
  assign sum_x   = cnt_x + step_x;
  assign diff_x  = cnt_x - step_x;
  assign floor_x = lo_x + step_x;

  // Next count and boundary detection. A load, an inverted limit pair and a
  // zero step all leave the count to the load or hold path with no event.
  always_comb begin
    nxt_count = count;
    hit_ovf   = 1'b0;
    hit_unf   = 1'b0;
    if (!load && enable && !cfg_err && (step != '0)) begin
      if (up_down) begin
        if (sum_x > hi_x) begin
          hit_ovf   = 1'b1;
          nxt_count = sat_mode ? lim_hi : lim_lo;
        end else begin
          nxt_count = sum_x[WIDTH-1:0];
        end
      end else begin
        if (cnt_x < floor_x) begin
          hit_unf   = 1'b1;
          nxt_count = sat_mode ? lim_lo : lim_hi;
        end else begin
          nxt_count = diff_x[WIDTH-1:0];
        end
      end
    end
  end

  // Count, event pulse and sticky flags; a new event beats a same-edge clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= RESET_VAL;
      evt   <= 1'b0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      count <= load ? data_in : nxt_count;
      evt   <= hit_ovf | hit_unf;
      ovf   <= hit_ovf | (ovf & ~clr_flags);
      unf   <= hit_unf | (unf & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_updown_counter_lim.sv
// Scoreboarded directed test of updown_counter_lim (WIDTH=8, STEP_W=4).
// Stimulus pushes the expected {count,evt,ovf,unf,cfg_err} for each edge.
// A monitor pops the expected value and compares it one step after each rising edge.
module tb_updown_counter_lim;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       up_down;
  logic       load;
  logic [7:0] data_in;
  logic [3:0] step;
  logic [7:0] lim_lo;
  logic [7:0] lim_hi;
  logic       sat_mode;
  logic       clr_flags;
  logic [7:0] count;
  logic       evt;
  logic       ovf;
  logic       unf;
  logic       cfg_err;

  logic [11:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  updown_counter_lim #(.WIDTH(8), .STEP_W(4), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down), .load(load),
    .data_in(data_in), .step(step), .lim_lo(lim_lo), .lim_hi(lim_hi),
    .sat_mode(sat_mode), .clr_flags(clr_flags), .count(count), .evt(evt),
    .ovf(ovf), .unf(unf), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got count=%h evt=%b ovf=%b unf=%b cfg_err=%b required count=%h evt=%b ovf=%b unf=%b cfg_err=%b",
               nm, act[11:4], act[3], act[2], act[1], act[0],
               exp[11:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Queue the response expected after the next rising edge, then wait for the falling edge.
  task automatic tick(input string nm, input logic [7:0] ec, input logic ee,
                      input logic eo, input logic eu);
    logic ecf;
    ecf = (lim_lo > lim_hi);
    exp_q.push_back({ec, ee, eo, eu, ecf});
    name_q.push_back(nm);
    @(negedge clk);
  endtask

  // Monitor: compares every rising-edge result against the scoreboard.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        check(name_q.pop_front(), {count, evt, ovf, unf, cfg_err}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    rst = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0; data_in = 8'h00;
    step = 4'd1; lim_lo = 8'h00; lim_hi = 8'hFF; sat_mode = 1'b0; clr_flags = 1'b0;
    #2;
    check("reset_state", {count, evt, ovf, unf, cfg_err}, 12'h000);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-run while count=0x37 with evt and ovf high.
    lim_lo = 8'h37; lim_hi = 8'h40;
    load = 1'b1; data_in = 8'h40;      tick("t1_load40", 8'h40, 0, 0, 0);
    load = 1'b0; enable = 1'b1;        tick("t1_wrap37", 8'h37, 1, 1, 0);
    enable = 1'b0;
    #2 rst = 1'b1;
    #1 check("t1_async_rst", {count, evt, ovf, unf, cfg_err}, 12'h000);
    @(negedge clk);
    rst = 1'b0; lim_lo = 8'h00; lim_hi = 8'hFF; enable = 1'b1; up_down = 1'b1; step = 4'd1;
    tick("t1_first_up", 8'h01, 0, 0, 0);

    // Wrap up through lim_hi=10.
    lim_lo = 8'd2; lim_hi = 8'd10; step = 4'd3; sat_mode = 1'b0;
    enable = 1'b0; load = 1'b1; data_in = 8'd4; tick("t2_load4", 8'd4, 0, 0, 0);
    load = 1'b0; enable = 1'b1;
    tick("t2_up7",   8'd7,  0, 0, 0);
    tick("t2_up10",  8'd10, 0, 0, 0);
    tick("t2_wrap2", 8'd2,  1, 1, 0);
    enable = 1'b0;
    tick("t2_hold",  8'd2,  0, 1, 0);

    // Saturating down count to lim_lo=5.
    clr_flags = 1'b1;                  tick("t3_clr", 8'd2, 0, 0, 0);
    clr_flags = 1'b0;
    lim_lo = 8'd5; lim_hi = 8'd200; step = 4'd4; sat_mode = 1'b1; up_down = 1'b0;
    load = 1'b1; data_in = 8'd11;      tick("t3_load11", 8'd11, 0, 0, 0);
    load = 1'b0; enable = 1'b1;
    tick("t3_dn7",   8'd7, 0, 0, 1'b0);
    tick("t3_sat5a", 8'd5, 1, 0, 1);
    tick("t3_sat5b", 8'd5, 1, 0, 1);

    // Load beats enable and may land outside the limits.
    lim_lo = 8'h03; lim_hi = 8'h20; step = 4'd1; sat_mode = 1'b0; up_down = 1'b1;
    load = 1'b1; data_in = 8'hF0;      tick("t4_load_f0", 8'hF0, 0, 0, 1);
    load = 1'b0;                       tick("t4_oor_wrap", 8'h03, 1, 1, 1);
    load = 1'b1;                       tick("t4_reload", 8'hF0, 0, 1, 1);
    load = 1'b0; step = 4'd0;          tick("t4_step0", 8'hF0, 0, 1, 1);

    // Saturate up when already past lim_hi.
    step = 4'd2; sat_mode = 1'b1; lim_lo = 8'h00;
    load = 1'b1; data_in = 8'h30;      tick("t4_load30", 8'h30, 0, 1, 1);
    load = 1'b0;                       tick("t4_sat_hi", 8'h20, 1, 1, 1);

    // Full-range wrap in both directions.
    enable = 1'b0; clr_flags = 1'b1; lim_lo = 8'h00; lim_hi = 8'hFF; step = 4'd1; sat_mode = 1'b0;
    tick("t5_clr", 8'h20, 0, 0, 0);
    clr_flags = 1'b0;
    load = 1'b1; data_in = 8'hFF;      tick("t5_load_ff", 8'hFF, 0, 0, 0);
    load = 1'b0; enable = 1'b1;        tick("t5_up_wrap", 8'h00, 1, 1, 0);
    up_down = 1'b0;                    tick("t5_dn_wrap", 8'hFF, 1, 1, 1);

    // Inverted limits block counting; set beats clear.
    lim_lo = 8'd20; lim_hi = 8'd10; up_down = 1'b1;
    tick("t6_cfg_err", 8'hFF, 0, 1, 1);
    lim_lo = 8'h00; lim_hi = 8'hFF; clr_flags = 1'b1;
    tick("t6_set_wins", 8'h00, 1, 1, 0);
    enable = 1'b0;
    tick("t6_clr_only", 8'h00, 0, 0, 0);
    clr_flags = 1'b0;

    w = 0;
    while (exp_q.size() != 0 && w < 10) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain got %0d pending entries required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
